align_pipe: RTL

ALIGN_PIPE -- requirements
Module: align_pipe

---
 rtl/align_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/align_pipe.sv
// Two-stage floating-point operand alignment: S1 orders the operands by magnitude,
// S2 right-shifts the smaller mantissa by the exponent gap with sticky folding.
module align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 28
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   num_a,
    input  logic [EXP_W+MAN_W:0]   num_b,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   swap,
    output logic                   s_max,
    output logic                   s_min,
    output logic                   eff_sub,
    output logic [EXP_W-1:0]       e_max,
    output logic [MAN_W-1:0]       m_max,
    output logic [MAN_W-1:0]       m_align
);
    localparam int SH_W = $clog2(MAN_W + 1);
    localparam logic [SH_W-1:0] SH_MAX = SH_W'(MAN_W);

    function automatic logic [SH_W-1:0] clamp_shift(input logic [EXP_W-1:0] diff);
        if (32'(diff) >= 32'(MAN_W))
            return SH_MAX;
        return SH_W'(diff);
    endfunction

    // Bits pushed off the bottom collapse into bit 0 so rounding still sees them.
    function automatic logic [MAN_W-1:0] sticky_shift(input logic [MAN_W-1:0] m,
                                                      input logic [SH_W-1:0]  sh);
        logic [MAN_W-1:0] mask;
        logic [MAN_W-1:0] r;
        if (sh >= SH_MAX)
            return {{(MAN_W-1){1'b0}}, |m};
        mask = ~({MAN_W{1'b1}} << sh);
        r    = m >> sh;
        r[0] = r[0] | (|(m & mask));
        return r;
    endfunction

    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     ma, mb;
    logic                 swap_c;
    logic [EXP_W-1:0]     diff_c;

    assign sa = num_a[EXP_W+MAN_W];
    assign sb = num_b[EXP_W+MAN_W];
    assign ea = num_a[EXP_W+MAN_W-1:MAN_W];
    assign eb = num_b[EXP_W+MAN_W-1:MAN_W];
    assign ma = num_a[MAN_W-1:0];
    assign mb = num_b[MAN_W-1:0];

    assign swap_c = !((ea > eb) || ((ea == eb) && (ma >= mb)));
    assign diff_c = swap_c ? (eb - ea) : (ea - eb);

    logic                 vld_p1, vld_p2;
    logic                 swap_p1, s_max_p1, s_min_p1, eff_sub_p1;
    logic [EXP_W-1:0]     e_max_p1;
    logic [MAN_W-1:0]     m_max_p1, m_min_p1;
    logic [SH_W-1:0]      sh_p1;
    logic                 swap_p2, s_max_p2, s_min_p2, eff_sub_p2;
    logic [EXP_W-1:0]     e_max_p2;
    logic [MAN_W-1:0]     m_max_p2, m_align_p2;

    logic s2_free, s1_adv, accept;

    assign s2_free  = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_free;
    assign in_ready = !flush && (!vld_p1 || s2_free);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (!vld_p1 || s2_free)
                vld_p1 <= in_valid;
            if (s2_free)
                vld_p2 <= vld_p1;
        end
    end

    // S1: magnitude compare and clamped exponent gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_p1    <= 1'b0;
            s_max_p1   <= 1'b0;
            s_min_p1   <= 1'b0;
            eff_sub_p1 <= 1'b0;
            e_max_p1   <= '0;
            m_max_p1   <= '0;
            m_min_p1   <= '0;
            sh_p1      <= '0;
        end else if (accept) begin
            swap_p1    <= swap_c;
            s_max_p1   <= swap_c ? sb : sa;
            s_min_p1   <= swap_c ? sa : sb;
            eff_sub_p1 <= sa ^ sb;
            e_max_p1   <= swap_c ? eb : ea;
            m_max_p1   <= swap_c ? mb : ma;
            m_min_p1   <= swap_c ? ma : mb;
            sh_p1      <= clamp_shift(diff_c);
        end
    end

    // S2: alignment shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_p2    <= 1'b0;
            s_max_p2   <= 1'b0;
            s_min_p2   <= 1'b0;
            eff_sub_p2 <= 1'b0;
            e_max_p2   <= '0;
            m_max_p2   <= '0;
            m_align_p2 <= '0;
        end else if (s1_adv) begin
            swap_p2    <= swap_p1;
            s_max_p2   <= s_max_p1;
            s_min_p2   <= s_min_p1;
            eff_sub_p2 <= eff_sub_p1;
            e_max_p2   <= e_max_p1;
            m_max_p2   <= m_max_p1;
            m_align_p2 <= sticky_shift(m_min_p1, sh_p1);
        end
    end

    assign out_valid = vld_p2;
    assign swap      = swap_p2;
    assign s_max     = s_max_p2;
    assign s_min     = s_min_p2;
    assign eff_sub   = eff_sub_p2;
    assign e_max     = e_max_p2;
    assign m_max     = m_max_p2;
    assign m_align   = m_align_p2;
endmodule
